// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Converts the asynchronous active-low board reset into NUM_CHANNELS active-high
// resets that assert immediately and release one by one, in step with Clock:
//   SYNC    : deassert synchronizer fills with ones
//   HOLD    : every channel stays asserted for HOLD_CYCLES cycles
//   STAGGER : channel k releases STAGGER_CYCLES cycles after channel k-1
//   RUN     : every channel released, oReady high
//   WDT     : one-cycle watchdog bite (only with RESET_SEQ_WATCHDOG_EN)
// A one-cycle iSwReset pulse in HOLD/STAGGER/RUN re-asserts every channel and
// restarts from HOLD. The synchronizer is not rerun, because Clock is already
// running and stable.
//
// Optional feature: define RESET_SEQ_WATCHDOG_EN to add a RUN-state watchdog.
// The watchdog is serviced by iKick and times out after WDT_CYCLES cycles.
// Without the macro, iKick is ignored and the WDT state is never entered.
//
// Parameters:
//   NUM_CHANNELS   number of reset outputs (1..16)
//   SYNC_STAGES    deassert synchronizer depth (2..4)
//   HOLD_CYCLES    common hold time after synchronized deassert (>=1)
//   STAGGER_CYCLES spacing between channel releases (0 = release together)
//   WDT_CYCLES     watchdog timeout (watchdog builds only)
//
// Ports:
//   Clock     in   system clock
//   Reset     in   asynchronous active-low board reset
//   iSwReset  in   single-cycle software re-sequence request
//   iKick     in   watchdog service pulse
//   oReset    out  [NUM_CHANNELS] per-channel active-high reset, bit k releases k-th
//   oReady    out  high once every channel is released
//   oState    out  [3] FSM state: SYNC=0 HOLD=1 STAGGER=2 RUN=3 WDT=4
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int NUM_CHANNELS   = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int WDT_CYCLES     = 1024
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    iSwReset,
  input  logic                    iKick,
  output logic [NUM_CHANNELS-1:0] oReset,
  output logic                    oReady,
  output logic [2:0]              oState
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int STAG_W = $clog2(STAGGER_CYCLES) + 1;
  localparam int CH_W   = $clog2(NUM_CHANNELS) + 1;

  // The terminal stagger count is clamped so that STAGGER_CYCLES = 0 still
  // yields a legal constant. That value is never reached, because that
  // configuration releases every channel at once on leaving HOLD.
  localparam int STAG_LAST_I = (STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAG_LAST_I);
  localparam logic [CH_W-1:0]   CH_ALL    = CH_W'(NUM_CHANNELS);

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_STAGGER = 3'd2,
    ST_RUN     = 3'd3,
    ST_WDT     = 3'd4
  } state_t;

  state_t                  state_reg, state_next;
  logic [SYNC_STAGES-1:0]  sync_reg;
  logic [HOLD_W-1:0]       hold_cnt_reg, hold_cnt_next;
  logic [STAG_W-1:0]       stag_cnt_reg, stag_cnt_next;
  logic [CH_W-1:0]         ch_idx_reg, ch_idx_next;
  logic [NUM_CHANNELS-1:0] rst_out_reg, rst_out_next;
  logic                    ready_reg, ready_next;
  logic [NUM_CHANNELS-1:0] ch_sel;
  logic                    sync_done;
  logic                    restart;
  logic                    wdt_bite;

  // ---------------------------------------------------------------------------
  // Deassert synchronizer. It clears asynchronously and shifts ones in while
  // Reset is high.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_done = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // One-hot decode of the next channel to release. ch_idx is 0 throughout
  // HOLD, so leaving HOLD releases channel 0 through the same path that
  // STAGGER uses for the other channels.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch_sel
      assign ch_sel[gi] = (ch_idx_reg == CH_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES) + 1;
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt_reg, wdt_cnt_next;

  // A kick in the same cycle as the terminal count wins, so no bite occurs.
  assign wdt_bite = (state_reg == ST_RUN) && !iKick && (wdt_cnt_reg == WDT_LAST);

  always_comb begin
    wdt_cnt_next = wdt_cnt_reg;
    if ((state_reg != ST_RUN) || (state_next != ST_RUN) || iKick) begin
      wdt_cnt_next = '0;
    end else if (wdt_cnt_reg != WDT_LAST) begin
      wdt_cnt_next = wdt_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wdt_cnt_reg <= '0;
    end else begin
      wdt_cnt_reg <= wdt_cnt_next;
    end
  end
`else
  // iKick and WDT_CYCLES feed dangling sinks, so they have no effect.
  localparam int wdt_cycles_unused = WDT_CYCLES;
  logic kick_unused;
  assign kick_unused = iKick;
  assign wdt_bite    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    stag_cnt_next = stag_cnt_reg;
    ch_idx_next   = ch_idx_reg;
    rst_out_next  = rst_out_reg;
    ready_next    = ready_reg;
    restart       = 1'b0;

    unique case (state_reg)
      ST_SYNC: begin
        // iSwReset has no meaning until the synchronizer has filled.
        if (sync_done) begin
          state_next    = ST_HOLD;
          hold_cnt_next = '0;
          ch_idx_next   = '0;
        end
      end

      ST_HOLD: begin
        if (iSwReset) begin
          restart = 1'b1;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next    = ST_STAGGER;
          stag_cnt_next = '0;
          if (STAGGER_CYCLES == 0) begin
            rst_out_next = '0;
            ch_idx_next  = CH_ALL;
          end else begin
            rst_out_next = rst_out_reg & ~ch_sel;
            ch_idx_next  = ch_idx_reg + 1'b1;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end

      ST_STAGGER: begin
        if (iSwReset) begin
          restart = 1'b1;
        end else if (ch_idx_reg >= CH_ALL) begin
          // The last channel released on the previous edge.
          state_next = ST_RUN;
          ready_next = 1'b1;
        end else if (stag_cnt_reg == STAG_LAST) begin
          rst_out_next  = rst_out_reg & ~ch_sel;
          ch_idx_next   = ch_idx_reg + 1'b1;
          stag_cnt_next = '0;
        end else begin
          stag_cnt_next = stag_cnt_reg + 1'b1;
        end
      end

      ST_RUN: begin
        if (iSwReset) begin
          restart = 1'b1;
        end else if (wdt_bite) begin
          state_next   = ST_WDT;
          rst_out_next = '1;
          ready_next   = 1'b0;
        end
      end

      ST_WDT: begin
        restart = 1'b1;
      end

      default: begin
        state_next   = ST_SYNC;
        rst_out_next = '1;
        ready_next   = 1'b0;
      end
    endcase

    // Software request, or the cycle after a watchdog bite: every channel
    // asserts again and HOLD starts from zero. The synchronizer is not rerun.
    if (restart) begin
      state_next    = ST_HOLD;
      hold_cnt_next = '0;
      stag_cnt_next = '0;
      ch_idx_next   = '0;
      rst_out_next  = '1;
      ready_next    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register. Every output comes straight from a flop here, so no
  // combinational path reaches oReset apart from the asynchronous assertion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= ST_SYNC;
      hold_cnt_reg <= '0;
      stag_cnt_reg <= '0;
      ch_idx_reg   <= '0;
      rst_out_reg  <= '1;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      stag_cnt_reg <= stag_cnt_next;
      ch_idx_reg   <= ch_idx_next;
      rst_out_reg  <= rst_out_next;
      ready_reg    <= ready_next;
    end
  end

  assign oReset = rst_out_reg;
  assign oReady = ready_reg;
  assign oState = state_reg;

endmodule
